// File: rtl/sound_event_arbiter.sv
// Sound-event arbiter: latches one-cycle event requests, grants them one at a time by
// fixed priority to the shared tone generator, and times each tone plus its silence gap.
module sound_event_arbiter #(
  parameter int unsigned  DUR_WALL  = 32'd1_500_000,
  parameter int unsigned  DUR_HIT   = 32'd3_000_000,
  parameter int unsigned  DUR_SCORE = 32'd10_000_000,
  parameter int unsigned  DUR_OVER  = 32'd25_000_000,
  parameter int unsigned  GAP       = 32'd500_000,
  parameter logic [17:0]  HP_WALL   = 18'd113636,
  parameter logic [17:0]  HP_HIT    = 18'd56818,
  parameter logic [17:0]  HP_SCORE  = 18'd37878,
  parameter logic [17:0]  HP_OVER   = 18'd151515
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_wall,
  input  logic        req_hit,
  input  logic        req_score,
  input  logic        req_over,
  input  logic        mute,
  input  logic        bgm_en,
  output logic        tone_en,
  output logic [17:0] tone_halfper,
  output logic [1:0]  active_id,
  output logic        busy,
  output logic        bgm_gate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP_ST = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  pending, pending_next;
  logic [31:0] counter, counter_next;
  logic        tone_en_next;
  logic [17:0] halfper_next;
  logic [1:0]  id_next;
  logic        busy_next;
  logic        bgm_gate_next;

  logic [3:0]  reqs;
  logic [3:0]  pend_req;
  logic        has_req;
  logic [1:0]  top_id;
  logic        grant;

  function automatic logic [31:0] dur_load(input logic [1:0] id);
    case (id)
      2'd0:    dur_load = DUR_WALL - 32'd1;
      2'd1:    dur_load = DUR_HIT - 32'd1;
      2'd2:    dur_load = DUR_SCORE - 32'd1;
      2'd3:    dur_load = DUR_OVER - 32'd1;
      default: dur_load = 32'd0;
    endcase
  endfunction

  function automatic logic [17:0] hp_of(input logic [1:0] id);
    case (id)
      2'd0:    hp_of = HP_WALL;
      2'd1:    hp_of = HP_HIT;
      2'd2:    hp_of = HP_SCORE;
      2'd3:    hp_of = HP_OVER;
      default: hp_of = 18'd0;
    endcase
  endfunction

  // Merge new requests into pending and pick the highest-priority candidate
  always_comb begin
    reqs     = mute ? 4'b0000 : {req_over, req_score, req_hit, req_wall};
    pend_req = pending | reqs;
    has_req  = |pend_req;
    if (pend_req[3])      top_id = 2'd3;
    else if (pend_req[2]) top_id = 2'd2;
    else if (pend_req[1]) top_id = 2'd1;
    else                  top_id = 2'd0;
  end

  // Next-state and next-output logic
  always_comb begin
    state_next    = state;
    pending_next  = pend_req;
    counter_next  = counter;
    tone_en_next  = tone_en;
    halfper_next  = tone_halfper;
    id_next       = active_id;
    grant         = 1'b0;

    case (state)
      IDLE: begin
        if (has_req) grant = 1'b1;
        else         state_next = IDLE;
      end
      PLAY: begin
        // A strictly higher-priority request cuts the current tone short, even on its last cycle
        if (has_req && (top_id > active_id)) begin
          grant = 1'b1;
        end else if (counter == 32'd0) begin
          state_next   = GAP_ST;
          counter_next = GAP - 32'd1;
          tone_en_next = 1'b0;
          halfper_next = 18'd0;
          id_next      = 2'd0;
        end else begin
          counter_next = counter - 32'd1;
        end
      end
      GAP_ST: begin
        if (counter == 32'd0) begin
          if (has_req) grant = 1'b1;
          else         state_next = IDLE;
        end else begin
          counter_next = counter - 32'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (mute) begin
      state_next   = IDLE;
      pending_next = 4'b0000;
      counter_next = 32'd0;
      tone_en_next = 1'b0;
      halfper_next = 18'd0;
      id_next      = 2'd0;
    end else if (grant) begin
      state_next   = PLAY;
      pending_next = pend_req & ~(4'b0001 << top_id);
      counter_next = dur_load(top_id);
      tone_en_next = 1'b1;
      halfper_next = hp_of(top_id);
      id_next      = top_id;
    end else begin
      pending_next = pend_req;
    end

    busy_next     = (state_next != IDLE);
    bgm_gate_next = bgm_en & ~busy_next & ~mute;
  end

  // State, pending and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= 4'b0000;
      counter      <= 32'd0;
      tone_en      <= 1'b0;
      tone_halfper <= 18'd0;
      active_id    <= 2'd0;
      busy         <= 1'b0;
      bgm_gate     <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      counter      <= counter_next;
      tone_en      <= tone_en_next;
      tone_halfper <= halfper_next;
      active_id    <= id_next;
      busy         <= busy_next;
      bgm_gate     <= bgm_gate_next;
    end
  end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed self-checking bench for sound_event_arbiter with shortened tone and gap lengths.
module tb_sound_event_arbiter;

  logic        clk;
  logic        rst;
  logic        req_wall, req_hit, req_score, req_over;
  logic        mute, bgm_en;
  logic        tone_en;
  logic [17:0] tone_halfper;
  logic [1:0]  active_id;
  logic        busy;
  logic        bgm_gate;

  int checks = 0;
  int errors = 0;

  // Packed view {tone_en, active_id, tone_halfper, busy}
  logic [21:0] obs;
  assign obs = {tone_en, active_id, tone_halfper, busy};

  localparam logic [21:0] IDLEV  = 22'd0;
  localparam logic [21:0] GAPV   = {1'b0, 2'd0, 18'd0, 1'b1};
  localparam logic [21:0] WALLV  = {1'b1, 2'd0, 18'd100, 1'b1};
  localparam logic [21:0] HITV   = {1'b1, 2'd1, 18'd200, 1'b1};
  localparam logic [21:0] SCOREV = {1'b1, 2'd2, 18'd300, 1'b1};
  localparam logic [21:0] OVERV  = {1'b1, 2'd3, 18'd400, 1'b1};

  sound_event_arbiter #(
    .DUR_WALL(32'd4), .DUR_HIT(32'd6), .DUR_SCORE(32'd10), .DUR_OVER(32'd12), .GAP(32'd3),
    .HP_WALL(18'd100), .HP_HIT(18'd200), .HP_SCORE(18'd300), .HP_OVER(18'd400)
  ) dut (
    .clk(clk), .rst(rst),
    .req_wall(req_wall), .req_hit(req_hit), .req_score(req_score), .req_over(req_over),
    .mute(mute), .bgm_en(bgm_en),
    .tone_en(tone_en), .tone_halfper(tone_halfper), .active_id(active_id),
    .busy(busy), .bgm_gate(bgm_gate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_wall = 1'b1; req_over = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== IDLEV || bgm_gate !== 1'b0) begin
      errors++; $display("FAIL reset_state: got %h/%b want %h/0", obs, bgm_gate, IDLEV);
    end
    rst = 1'b0; req_wall = 1'b0; req_over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== IDLEV) begin
        errors++; $display("FAIL reset_discard cyc%0d: got %h want %h", i, obs, IDLEV);
      end
    end
  endtask

  task automatic test_single();
    int          n [3] = '{6, 3, 2};
    logic [21:0] e [3] = '{HITV, GAPV, IDLEV};
    req_hit = 1'b1; tick(); req_hit = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < n[s]; i++) begin
        checks++;
        if (obs !== e[s]) begin
          errors++; $display("FAIL single seg%0d cyc%0d: got %h want %h", s, i, obs, e[s]);
        end
        tick();
      end
  endtask

  task automatic test_simultaneous();
    int          n [5] = '{10, 3, 4, 3, 2};
    logic [21:0] e [5] = '{SCOREV, GAPV, WALLV, GAPV, IDLEV};
    req_wall = 1'b1; req_score = 1'b1; tick(); req_wall = 1'b0; req_score = 1'b0;
    for (int s = 0; s < 5; s++)
      for (int i = 0; i < n[s]; i++) begin
        checks++;
        if (obs !== e[s]) begin
          errors++; $display("FAIL simultaneous seg%0d cyc%0d: got %h want %h", s, i, obs, e[s]);
        end
        tick();
      end
  endtask

  task automatic test_preempt();
    int          n [3] = '{12, 3, 6};
    logic [21:0] e [3] = '{OVERV, GAPV, IDLEV};
    req_wall = 1'b1; tick(); req_wall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== WALLV) begin
        errors++; $display("FAIL preempt_wall cyc%0d: got %h want %h", i, obs, WALLV);
      end
      if (i == 0) tick();
    end
    req_over = 1'b1; tick(); req_over = 1'b0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < n[s]; i++) begin
        checks++;
        if (obs !== e[s]) begin
          errors++; $display("FAIL preempt seg%0d cyc%0d: got %h want %h", s, i, obs, e[s]);
        end
        tick();
      end
  endtask

  task automatic test_no_preempt();
    int          n [7] = '{8, 3, 10, 3, 6, 3, 2};
    logic [21:0] e [7] = '{SCOREV, GAPV, SCOREV, GAPV, HITV, GAPV, IDLEV};
    req_score = 1'b1; tick(); req_score = 1'b0;
    checks++;
    if (obs !== SCOREV) begin
      errors++; $display("FAIL nopre_start: got %h want %h", obs, SCOREV);
    end
    tick();
    req_hit = 1'b1; req_score = 1'b1; tick(); req_hit = 1'b0; req_score = 1'b0;
    for (int s = 0; s < 7; s++)
      for (int i = 0; i < n[s]; i++) begin
        checks++;
        if (obs !== e[s]) begin
          errors++; $display("FAIL no_preempt seg%0d cyc%0d: got %h want %h", s, i, obs, e[s]);
        end
        tick();
      end
  endtask

  task automatic test_mute();
    req_score = 1'b1; tick(); req_score = 1'b0;
    req_hit = 1'b1; tick(); req_hit = 1'b0;
    checks++;
    if (obs !== SCOREV) begin
      errors++; $display("FAIL mute_pre: got %h want %h", obs, SCOREV);
    end
    mute = 1'b1; tick();
    checks++;
    if (obs !== IDLEV || bgm_gate !== 1'b0) begin
      errors++; $display("FAIL mute_silence: got %h/%b want %h/0", obs, bgm_gate, IDLEV);
    end
    req_over = 1'b1; req_wall = 1'b1; tick(); req_over = 1'b0; req_wall = 1'b0;
    tick();
    mute = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== IDLEV) begin
        errors++; $display("FAIL mute_flush cyc%0d: got %h want %h", i, obs, IDLEV);
      end
    end
  endtask

  task automatic test_bgm_reset();
    bgm_en = 1'b1; tick();
    checks++;
    if (bgm_gate !== 1'b1 || obs !== IDLEV) begin
      errors++; $display("FAIL bgm_idle: got %b/%h want 1/%h", bgm_gate, obs, IDLEV);
    end
    req_wall = 1'b1; tick(); req_wall = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bgm_gate !== 1'b0 || obs !== ((i < 4) ? WALLV : GAPV)) begin
        errors++; $display("FAIL bgm_busy cyc%0d: got %b/%h want 0/%h", i, bgm_gate, obs,
                           (i < 4) ? WALLV : GAPV);
      end
      tick();
    end
    checks++;
    if (bgm_gate !== 1'b1 || obs !== IDLEV) begin
      errors++; $display("FAIL bgm_reopen: got %b/%h want 1/%h", bgm_gate, obs, IDLEV);
    end
    req_hit = 1'b1; tick(); req_hit = 1'b0;
    tick();
    checks++;
    if (obs !== HITV) begin
      errors++; $display("FAIL rst_pre: got %h want %h", obs, HITV);
    end
    req_wall = 1'b1; tick(); req_wall = 1'b0;
    rst = 1'b1; req_score = 1'b1; tick();
    checks++;
    if (obs !== IDLEV || bgm_gate !== 1'b0) begin
      errors++; $display("FAIL rst_mid_play: got %h/%b want %h/0", obs, bgm_gate, IDLEV);
    end
    rst = 1'b0; req_score = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== IDLEV || bgm_gate !== 1'b1) begin
        errors++; $display("FAIL rst_no_residual cyc%0d: got %h/%b want %h/1", i, obs, bgm_gate, IDLEV);
      end
    end
    bgm_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_wall = 1'b0; req_hit = 1'b0; req_score = 1'b0; req_over = 1'b0;
    mute = 1'b0; bgm_en = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_no_preempt();
    test_mute();
    test_bgm_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary line");
    $fatal(1);
  end

endmodule
